// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM pipeline stage.
// Holds the access FSM encoding, WB control bit positions and the index-width helper.
package mem_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  // Word-index width for a DEPTH-word memory; never narrower than one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_stage_data_mem.sv
// Word-addressed data memory: synchronous write, asynchronous read.
// Contents are not touched by reset.
module data_mem #(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_addr,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: branch resolve, wait-stated data-memory access with upstream stall,
// and the MEM/WB pipeline register. dbg_state exposes the access FSM (1 = ACCESS).
module mem_stage
  import mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  wb_ctlout,
  input  logic        branch,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] add_result,
  input  logic        zero,
  input  logic [31:0] alu_result,
  input  logic [31:0] rdata2out,
  input  logic [4:0]  five_bit_muxout,
  output logic        pcsrc,
  output logic [31:0] branch_target,
  output logic        stall,
  output logic        misalign,
  output logic        regwrite_wb,
  output logic        memtoreg_wb,
  output logic [31:0] read_data,
  output logic [31:0] alu_result_wb,
  output logic [4:0]  write_reg_wb,
  output logic        dbg_state
);

  localparam int IDX_W = idx_width(DEPTH);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic HAS_WAIT = (WAIT_CYCLES > 0);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_stall;
  logic             w_complete;
  logic             w_memop;
  logic             w_misalign_op;
  logic             w_we;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_mem_rdata;
  logic [31:0]      w_load_data;

  logic             r_regwrite;
  logic             r_memtoreg;
  logic             r_misalign;
  logic [31:0]      r_read_data;
  logic [31:0]      r_alu_result;
  logic [4:0]       r_write_reg;

  assign w_memop       = memread | memwrite;
  assign w_misalign_op = w_memop & (|alu_result[1:0]);
  assign w_idx         = alu_result[IDX_W+1:2];
  // Gating with rst keeps a store that is completing while reset is held from committing.
  assign w_we          = w_complete & memwrite & ~w_misalign_op & ~rst;
  assign w_load_data   = (w_misalign_op | (memread & memwrite)) ? 32'h0 : w_mem_rdata;

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_stall      = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_memop && HAS_WAIT) begin
          w_next_state = ACCESS;
          w_next_cnt   = CNT_LOAD;
          w_stall      = 1'b1;
        end else begin
          w_complete = 1'b1;
        end
      end
      ACCESS: begin
        if (r_cnt != '0) begin
          w_next_cnt = r_cnt - CNT_W'(1);
          w_stall    = 1'b1;
        end else begin
          w_next_state = IDLE;
          w_complete   = 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_regwrite   <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_misalign   <= 1'b0;
      r_read_data  <= 32'h0;
      r_alu_result <= 32'h0;
      r_write_reg  <= 5'h0;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_next_cnt;
      r_misalign <= w_complete & w_misalign_op;
      if (w_complete) begin
        r_regwrite   <= wb_ctlout[WB_REGWRITE];
        r_memtoreg   <= wb_ctlout[WB_MEMTOREG];
        r_read_data  <= w_load_data;
        r_alu_result <= alu_result;
        r_write_reg  <= five_bit_muxout;
      end else begin
        // Bubble into write-back; data fields keep their last values.
        r_regwrite <= 1'b0;
        r_memtoreg <= 1'b0;
      end
    end
  end

  data_mem #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_data_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_idx),
    .i_wdata (rdata2out),
    .o_rdata (w_mem_rdata)
  );

  assign pcsrc         = branch & zero;
  assign branch_target = add_result;
  assign stall         = w_stall;
  assign misalign      = r_misalign;
  assign regwrite_wb   = r_regwrite;
  assign memtoreg_wb   = r_memtoreg;
  assign read_data     = r_read_data;
  assign alu_result_wb = r_alu_result;
  assign write_reg_wb  = r_write_reg;
  assign dbg_state     = (r_state == ACCESS);

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: one instance with WAIT_CYCLES=2, one with WAIT_CYCLES=0.
// Inputs are shared; the instance not under test is held in reset.
module tb_mem_stage;

  localparam int DEPTH = 256;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int EW    = 72;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  logic [1:0]  wb_ctlout;
  logic        branch, memread, memwrite, zero;
  logic [31:0] add_result, alu_result, rdata2out;
  logic [4:0]  five_bit_muxout;
  logic        sel;

  logic        a_pcsrc, a_stall, a_misalign, a_regwrite_wb, a_memtoreg_wb, a_dbg_state;
  logic [31:0] a_branch_target, a_read_data, a_alu_result_wb;
  logic [4:0]  a_write_reg_wb;
  logic        b_pcsrc, b_stall, b_misalign, b_regwrite_wb, b_memtoreg_wb, b_dbg_state;
  logic [31:0] b_branch_target, b_read_data, b_alu_result_wb;
  logic [4:0]  b_write_reg_wb;

  mem_stage #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .rst(rst_a), .wb_ctlout(wb_ctlout), .branch(branch), .memread(memread),
    .memwrite(memwrite), .add_result(add_result), .zero(zero), .alu_result(alu_result),
    .rdata2out(rdata2out), .five_bit_muxout(five_bit_muxout), .pcsrc(a_pcsrc),
    .branch_target(a_branch_target), .stall(a_stall), .misalign(a_misalign),
    .regwrite_wb(a_regwrite_wb), .memtoreg_wb(a_memtoreg_wb), .read_data(a_read_data),
    .alu_result_wb(a_alu_result_wb), .write_reg_wb(a_write_reg_wb), .dbg_state(a_dbg_state)
  );

  mem_stage #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst(rst_b), .wb_ctlout(wb_ctlout), .branch(branch), .memread(memread),
    .memwrite(memwrite), .add_result(add_result), .zero(zero), .alu_result(alu_result),
    .rdata2out(rdata2out), .five_bit_muxout(five_bit_muxout), .pcsrc(b_pcsrc),
    .branch_target(b_branch_target), .stall(b_stall), .misalign(b_misalign),
    .regwrite_wb(b_regwrite_wb), .memtoreg_wb(b_memtoreg_wb), .read_data(b_read_data),
    .alu_result_wb(b_alu_result_wb), .write_reg_wb(b_write_reg_wb), .dbg_state(b_dbg_state)
  );

  logic        pcsrc, stall, misalign, regwrite_wb, memtoreg_wb, dbg_state;
  logic [31:0] branch_target, read_data, alu_result_wb;
  logic [4:0]  write_reg_wb;
  assign pcsrc         = sel ? b_pcsrc         : a_pcsrc;
  assign stall         = sel ? b_stall         : a_stall;
  assign misalign      = sel ? b_misalign      : a_misalign;
  assign regwrite_wb   = sel ? b_regwrite_wb   : a_regwrite_wb;
  assign memtoreg_wb   = sel ? b_memtoreg_wb   : a_memtoreg_wb;
  assign dbg_state     = sel ? b_dbg_state     : a_dbg_state;
  assign branch_target = sel ? b_branch_target : a_branch_target;
  assign read_data     = sel ? b_read_data     : a_read_data;
  assign alu_result_wb = sel ? b_alu_result_wb : a_alu_result_wb;
  assign write_reg_wb  = sel ? b_write_reg_wb  : a_write_reg_wb;

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [31:0]   mdl [2][DEPTH];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_wb_zero(input string tag);
    check({tag, "_regwrite"}, 32'(regwrite_wb), 32'h0);
    check({tag, "_memtoreg"}, 32'(memtoreg_wb), 32'h0);
    check({tag, "_misalign"}, 32'(misalign), 32'h0);
    check({tag, "_read_data"}, read_data, 32'h0);
    check({tag, "_alu_wb"}, alu_result_wb, 32'h0);
    check({tag, "_write_reg"}, 32'(write_reg_wb), 32'h0);
    check({tag, "_state"}, 32'(dbg_state), 32'h0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_nop();
    memread = 1'b0; memwrite = 1'b0; branch = 1'b0; zero = 1'b0;
    wb_ctlout = 2'b00; add_result = 32'h0; alu_result = 32'h0;
    rdata2out = 32'h0; five_bit_muxout = 5'h0;
  endtask

  // Called at posedge+1; presents one instruction, checks every cycle until completion.
  task automatic run_op(input logic mr, input logic mw, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] wb, input logic [4:0] rd,
                        input logic br, input logic z, input logic [31:0] tgt);
    logic             memop, mis, both;
    logic [IDX_W-1:0] idx;
    logic [31:0]      rdat;
    logic [EW-1:0]    e;
    int               w;
    memop = mr | mw;
    both  = mr & mw;
    mis   = memop && (addr[1:0] != 2'b00);
    idx   = addr[IDX_W+1:2];
    rdat  = (mis || both) ? 32'h0 : mdl[sel][idx];
    w     = (memop && !sel) ? 2 : 0;
    memread = mr; memwrite = mw; alu_result = addr; rdata2out = wdata;
    wb_ctlout = wb; five_bit_muxout = rd; branch = br; zero = z; add_result = tgt;
    exp_q.push_back({wb[1], wb[0], mis, rd, addr, rdat});
    for (int c = 0; c <= w; c++) begin
      @(negedge clk);
      check("stall", 32'(stall), 32'(c < w));
      check("pcsrc", 32'(pcsrc), 32'(br & z));
      check("branch_target", branch_target, tgt);
      @(posedge clk);
      #1;
      if (c < w) begin
        check("bubble_regwrite", 32'(regwrite_wb), 32'h0);
        check("bubble_memtoreg", 32'(memtoreg_wb), 32'h0);
        check("bubble_misalign", 32'(misalign), 32'h0);
      end
    end
    e = exp_q.pop_front();
    check("regwrite_wb", 32'(regwrite_wb), 32'(e[71]));
    check("memtoreg_wb", 32'(memtoreg_wb), 32'(e[70]));
    check("misalign", 32'(misalign), 32'(e[69]));
    check("write_reg_wb", 32'(write_reg_wb), 32'(e[68:64]));
    check("alu_result_wb", alu_result_wb, e[63:32]);
    check("read_data", read_data, e[31:0]);
    if (mw && !mis) mdl[sel][idx] = wdata;
  endtask

  task automatic run_random(input int n);
    logic [31:0] addr;
    for (int i = 0; i < n; i++) begin
      addr = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 31)) << 2);
      if ($urandom_range(0, 5) == 0) addr = addr | 32'($urandom_range(1, 3));
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, $urandom,
             2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mdl[0][i] = 32'h0;
      mdl[1][i] = 32'h0;
    end
    sel = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    set_nop();
    repeat (2) @(posedge clk);
    #1;
    check_wb_zero("reset");
    check("reset_stall", 32'(stall), 32'h0);
    @(negedge clk);
    rst_a = 1'b0;
    @(posedge clk);
    #1;

    // WAIT_CYCLES=2 instance
    run_op(1'b0, 1'b0, 32'h1234, 32'h0, 2'b10, 5'd5, 1'b0, 1'b0, 32'h0);
    run_op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 5'd0, 1'b0, 1'b0, 32'h0);
    run_op(1'b1, 1'b0, 32'h10, 32'h0, 2'b11, 5'd7, 1'b0, 1'b0, 32'h0);
    run_op(1'b0, 1'b0, 32'h8, 32'h0, 2'b10, 5'd3, 1'b1, 1'b1, 32'h40);
    run_op(1'b0, 1'b1, 32'h30, 32'h0BADF00D, 2'b00, 5'd0, 1'b1, 1'b1, 32'h40);
    run_op(1'b0, 1'b0, 32'h8, 32'h0, 2'b10, 5'd3, 1'b1, 1'b0, 32'h40);
    run_op(1'b0, 1'b1, 32'h13, 32'h11112222, 2'b00, 5'd0, 1'b0, 1'b0, 32'h0);
    run_op(1'b1, 1'b0, 32'h10, 32'h0, 2'b11, 5'd9, 1'b0, 1'b0, 32'h0);
    run_op(1'b1, 1'b1, 32'h34, 32'h77778888, 2'b11, 5'd4, 1'b0, 1'b0, 32'h0);
    run_op(1'b1, 1'b0, 32'h34, 32'h0, 2'b11, 5'd4, 1'b0, 1'b0, 32'h0);

    // Reset during the first ACCESS cycle of a store
    memread = 1'b0; memwrite = 1'b1; alu_result = 32'h20; rdata2out = 32'h55;
    wb_ctlout = 2'b00; five_bit_muxout = 5'd0; branch = 1'b0; zero = 1'b0;
    @(posedge clk);
    #1;
    check("access_state", 32'(dbg_state), 32'h1);
    check("access_stall", 32'(stall), 32'h1);
    rst_a = 1'b1;
    set_nop();
    #1;
    check("midreset_stall", 32'(stall), 32'h0);
    check_wb_zero("midreset");
    @(negedge clk);
    rst_a = 1'b0;
    @(posedge clk);
    #1;
    run_op(1'b1, 1'b0, 32'h20, 32'h0, 2'b11, 5'd2, 1'b0, 1'b0, 32'h0);
    run_random(24);

    // WAIT_CYCLES=0 instance
    rst_a = 1'b1;
    set_nop();
    sel = 1'b1;
    #1;
    check_wb_zero("w0_reset");
    @(negedge clk);
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    run_op(1'b0, 1'b1, 32'h400, 32'hCAFEF00D, 2'b00, 5'd0, 1'b0, 1'b0, 32'h0);
    run_op(1'b1, 1'b0, 32'h0, 32'h0, 2'b11, 5'd6, 1'b0, 1'b0, 32'h0);
    run_op(1'b0, 1'b1, 32'h7, 32'h12345678, 2'b00, 5'd0, 1'b1, 1'b1, 32'h80);
    run_op(1'b1, 1'b0, 32'h4, 32'h0, 2'b11, 5'd1, 1'b0, 1'b0, 32'h0);
    run_random(16);

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage pipelined MIPS datapath. It sits directly downstream of the EX/MEM pipeline register and consumes its outputs. It resolves the branch decision, performs data-memory loads and stores against a word-addressed data memory with configurable wait states, stalls the upstream pipeline while an access is in flight, and registers the results into the MEM/WB pipeline register feeding write-back.

## Interface

Parameters:
- DEPTH, 256: data-memory size in 32-bit words; power of two.
- WAIT_CYCLES, 2: extra cycles per memory access (0 = single-cycle memory).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- wb_ctlout  in  2  WB controls: [1] regwrite, [0] memtoreg.
- branch  in  1  branch instruction.
- memread  in  1  load.
- memwrite  in  1  store.
- add_result  in  32  branch target from EX.
- zero  in  1  ALU zero flag.
- alu_result  in  32  ALU result; memory byte address for loads and stores.
- rdata2out  in  32  store data.
- five_bit_muxout  in  5  destination register.
- pcsrc  out  1  combinational branch & zero.
- branch_target  out  32  combinational copy of add_result.
- stall  out  1  combinational; when high, upstream registers and the PC must hold.
- misalign  out  1  registered one-cycle pulse: a memory op had alu_result[1:0] != 0.
- regwrite_wb  out  1  MEM/WB regwrite.
- memtoreg_wb  out  1  MEM/WB memtoreg.
- read_data  out  32  MEM/WB load data.
- alu_result_wb  out  32  MEM/WB ALU result.
- write_reg_wb  out  5  MEM/WB destination register.

## Operation

- A memory op means memread | memwrite. If both are set, treat it as a store, and read_data latches 0.
- Word index = alu_result[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH.
- Misaligned memory op: do not write memory, latch read_data = 0, and pulse misalign with the MEM/WB update. Timing, stall and WB controls are otherwise normal.
- FSM states:
  - IDLE: on a memory op with WAIT_CYCLES > 0, go to ACCESS and load cnt = WAIT_CYCLES-1. Otherwise stay in IDLE and complete in this cycle.
  - ACCESS: decrement cnt each cycle. At cnt == 0, complete and return to IDLE.
- Completion at a clock edge: the store commits to memory, and MEM/WB latches wb_ctlout, read_data (mem[index] before the store), alu_result and five_bit_muxout.
- stall = (IDLE & memop & WAIT_CYCLES>0) | (ACCESS & cnt != 0).
- While stall is high, MEM/WB latches a bubble: regwrite_wb = 0 and memtoreg_wb = 0. The data fields hold their previous values.
- Upstream must hold all inputs stable while stall is high. The block samples inputs only at completion.
- Non-memory instructions complete every cycle with no stall.
- pcsrc and branch_target are purely combinational and are not gated by stall.
- Reset (asynchronous, at any time, including mid-ACCESS):
  - Go to IDLE, cnt = 0.
  - All MEM/WB outputs and misalign go to 0.
  - An in-flight store is abandoned and does not commit.
  - Memory contents are unaffected by reset; memory is zero at time 0.

## Timing

- Non-memory op latency: 1 cycle (inputs present in cycle n, MEM/WB valid after edge n+1).
- Memory op latency: WAIT_CYCLES+1 cycles. stall is high for exactly WAIT_CYCLES cycles, starting in the cycle the op is first presented.
- Back-to-back memory ops: the second op is presented the cycle after completion. It enters IDLE→ACCESS with no dead cycle.
- A store followed immediately by a load to the same word returns the stored value.
- Memory write is synchronous. Read is combinational from the array, sampled at the completion edge.

## Structure

- Package mem_pkg:
  - state enum {IDLE, ACCESS}.
  - WB bit indices WB_REGWRITE = 1, WB_MEMTOREG = 0.
  - Helper function for word-index width, clog2(DEPTH).
- Sub-module data_mem: DEPTH×32 array with synchronous write enable and asynchronous read. The FSM, counter and MEM/WB register live in mem_stage.

## Test plan

- Reset, then ALU op (alu_result=0x1234, wb_ctlout=2'b10, rd=5) → no stall; next edge alu_result_wb=0x1234, regwrite_wb=1, write_reg_wb=5.
- WAIT_CYCLES=2: store 0xDEADBEEF at 0x10, then load 0x10 → each op stalls 2 cycles with bubbles; the load yields read_data=0xDEADBEEF, memtoreg_wb=1.
- branch=1, zero=1, add_result=0x40 → pcsrc=1 and branch_target=0x40 in the same cycle, during both stalled and unstalled cycles; with zero=0 → pcsrc=0.
- Store at 0x13 → misalign pulses 1 cycle; a subsequent load of 0x10 returns the old value.
- Assert rst in the first ACCESS cycle of a store of 0x55 to 0x20 → outputs 0, stall drops, state IDLE; a later load of 0x20 returns 0.
- WAIT_CYCLES=0, and DEPTH=256 wrap: store at 0x400 then load at 0x0 → no stall, read_data equals the stored value.
